// File: rtl/pulse_sweep_sequencer.sv
// Linear delay sweep sequencer for the pulse generator.
// Steps del_out from start by step over a number of points. Each point is held
// for a fixed number of shots counted on period_end, after a settle window
// whose shots are discarded.
module pulse_sweep_sequencer #(
  parameter int unsigned DW = 16,
  parameter int unsigned PW = 12,
  parameter int unsigned SW = 16,
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [DW-1:0] cfg_start,
  input  logic [DW-1:0] cfg_step,
  input  logic [PW-1:0] cfg_points,
  input  logic [SW-1:0] cfg_shots,
  input  logic [TW-1:0] cfg_settle,
  input  logic          period_end,
  input  logic          abort,
  output logic [DW-1:0] del_out,
  output logic          del_update,
  output logic          acq_en,
  output logic [PW-1:0] point_idx,
  output logic          point_done,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] ACQ    = 3'd3;
  localparam logic [2:0] STEP   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] start_q, start_d;
  logic [DW-1:0] step_q, step_d;
  logic [PW-1:0] points_q, points_d;
  logic [SW-1:0] shots_q, shots_d;
  logic [TW-1:0] settle_q, settle_d;
  logic [TW-1:0] settle_cnt_q, settle_cnt_d;
  logic [SW-1:0] shot_cnt_q, shot_cnt_d;

  logic [DW-1:0] del_d;
  logic [PW-1:0] idx_d;
  logic          err_d;
  logic          del_update_d, point_done_d, done_d;
  logic [DW:0]   sum;

  // Extra carry bit exposes step overflow.
  assign sum = {1'b0, del_out} + {1'b0, step_q};

  // Next-state and next-output decode; abort outranks everything outside IDLE.
  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    step_d       = step_q;
    points_d     = points_q;
    shots_d      = shots_q;
    settle_d     = settle_q;
    settle_cnt_d = settle_cnt_q;
    shot_cnt_d   = shot_cnt_q;
    del_d        = del_out;
    idx_d        = point_idx;
    err_d        = err;
    del_update_d = 1'b0;
    point_done_d = 1'b0;
    done_d       = 1'b0;

    if (state_q != IDLE && abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_valid && cfg_ready) begin
            start_d  = cfg_start;
            step_d   = cfg_step;
            points_d = cfg_points;
            shots_d  = cfg_shots;
            settle_d = cfg_settle;
            err_d    = 1'b0;
            state_d  = (cfg_points == '0 || cfg_shots == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          del_d        = start_q;
          idx_d        = '0;
          del_update_d = 1'b1;
          settle_cnt_d = '0;
          shot_cnt_d   = '0;
          state_d      = SETTLE;
        end
        SETTLE: begin
          // A zero settle count leaves after a single cycle.
          if (settle_cnt_q == settle_q) begin
            state_d = ACQ;
          end else if (period_end) begin
            if (settle_cnt_q + TW'(1) == settle_q) state_d = ACQ;
            else settle_cnt_d = settle_cnt_q + TW'(1);
          end
        end
        ACQ: begin
          if (period_end) begin
            if (shot_cnt_q + SW'(1) == shots_q) begin
              point_done_d = 1'b1;
              state_d      = (point_idx == points_q - PW'(1)) ? DONE : STEP;
            end else begin
              shot_cnt_d = shot_cnt_q + SW'(1);
            end
          end
        end
        STEP: begin
          if (sum[DW]) begin
            del_d   = '1;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            del_d        = sum[DW-1:0];
            idx_d        = point_idx + PW'(1);
            del_update_d = 1'b1;
            settle_cnt_d = '0;
            shot_cnt_d   = '0;
            state_d      = SETTLE;
          end
        end
        DONE: begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, shadow configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      start_q      <= '0;
      step_q       <= '0;
      points_q     <= '0;
      shots_q      <= '0;
      settle_q     <= '0;
      settle_cnt_q <= '0;
      shot_cnt_q   <= '0;
      del_out      <= '0;
      point_idx    <= '0;
      err          <= 1'b0;
      del_update   <= 1'b0;
      point_done   <= 1'b0;
      done         <= 1'b0;
      acq_en       <= 1'b0;
      busy         <= 1'b0;
      cfg_ready    <= 1'b1;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      step_q       <= step_d;
      points_q     <= points_d;
      shots_q      <= shots_d;
      settle_q     <= settle_d;
      settle_cnt_q <= settle_cnt_d;
      shot_cnt_q   <= shot_cnt_d;
      del_out      <= del_d;
      point_idx    <= idx_d;
      err          <= err_d;
      del_update   <= del_update_d;
      point_done   <= point_done_d;
      done         <= done_d;
      acq_en       <= (state_d == ACQ);
      busy         <= (state_d != IDLE);
      cfg_ready    <= (state_d == IDLE);
    end
  end

endmodule

// File: doc/pulse_sweep_sequencer.md
Name: pulse_sweep_sequencer

Overview:
- Steps the pulse generator's inter-pulse delay through a linear sweep, holding each point for a programmed number of shots.
- Sits between the host-side register interface and the pulse generator's `del` input; counts shots on the generator's period-boundary strobe.
- Gates the acquisition window so that shots taken while a new delay settles are discarded.
- Reports per-point and end-of-sweep progress to the host.

Parameters:
- DW, 16, width of delay and step values (matches the pulse generator delay input)
- PW, 12, width of the point counter
- SW, 16, width of the shot counter
- TW, 8, width of the settle-period counter

Ports:
- clk  in  1  system clock (50 MHz domain, same as the pulse-parameter registers)
- reset  in  1  synchronous, active-low reset
- cfg_valid  in  1  host presents a sweep configuration
- cfg_ready  out  1  sequencer can accept a configuration (high only in IDLE)
- cfg_start  in  DW  first delay value, in cycles
- cfg_step  in  DW  delay increment per point (unsigned)
- cfg_points  in  PW  number of sweep points
- cfg_shots  in  SW  shots acquired per point
- cfg_settle  in  TW  periods discarded after each delay change
- period_end  in  1  one-cycle strobe from the pulse generator at each period wrap
- abort  in  1  terminate the sweep
- del_out  out  DW  delay value driven to the pulse generator
- del_update  out  1  one-cycle strobe when del_out changes
- acq_en  out  1  high while shots count toward the current point
- point_idx  out  PW  index of the current point
- point_done  out  1  one-cycle strobe when a point's shots are complete
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle strobe at normal sweep completion
- err  out  1  sticky step-overflow flag; cleared on the next accepted configuration

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - del_out=0, point_idx=0, err=0.
  - del_update, acq_en, point_done, busy and done are all 0.
  - cfg_ready is 1 from the first cycle after reset.
  - Internal counters are cleared.
  - Reset dominates abort and cfg_valid.
- States are IDLE, LOAD, SETTLE, ACQ, STEP, DONE. All outputs are registered.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid&&cfg_ready, capture all cfg_* fields into shadow registers and clear err.
  - If cfg_points==0 or cfg_shots==0, go to DONE without touching del_out. Otherwise go to LOAD.
  - cfg_* changes outside the accept cycle have no effect.
- LOAD (1 cycle):
  - del_out<=start, point_idx<=0, del_update=1 for one cycle.
  - Clear the settle and shot counters, then go to SETTLE.
- SETTLE:
  - acq_en=0.
  - Count period_end strobes.
  - When the count equals settle, go to ACQ. With settle==0, go to ACQ on the cycle after entry.
- ACQ:
  - acq_en=1.
  - Each period_end increments the shot counter.
  - On the period_end that makes the count equal to shots:
    - point_done=1 for one cycle and acq_en drops on the next cycle.
    - If point_idx==points-1, go to DONE; otherwise go to STEP.
- STEP (1 cycle):
  - Compute a DW+1-bit sum of del_out and step.
  - If bit DW of the sum is set: del_out saturates to all ones, err<=1, no del_update, go to DONE.
  - Otherwise: del_out<=sum, point_idx++, del_update=1, clear the counters, go to SETTLE.
- DONE (1 cycle): done=1, then go to IDLE. del_out holds its last value.
- period_end handling:
  - period_end is sampled only in SETTLE and ACQ.
  - A strobe arriving in a LOAD or STEP cycle is not counted.
  - Because the delay change lands mid-period, settle>=1 is required for clean data; the sequencer does not enforce it.
- abort:
  - In any non-IDLE state, abort causes IDLE on the next cycle.
  - acq_en drops with that transition; done and point_done are not pulsed.
  - del_out and point_idx hold their values.
  - abort in IDLE is ignored.
  - abort has priority over simultaneous period_end.
- Counter widths:
  - Counters compare for equality against the shadow values, so no wrap occurs.
  - Max cfg_shots and max cfg_points are usable.

Test Plan:
1. Reset with reset=0 for 3 cycles, then release -> all outputs 0; cfg_ready=1 on the first cycle after release.
2. Basic sweep with start=200, step=50, points=3, shots=4, settle=1, period_end every 10 cycles:
   - del_out steps 200, 250, 300, with exactly 3 del_update strobes.
   - acq_en covers exactly 4 period_end strobes per point.
   - point_done fires 3 times and done fires once.
   - Final point_idx=2, err=0.
3. Degenerate configurations:
   - points=0 -> done 2 cycles after the accept cycle; del_out unchanged; no del_update.
   - shots=0 -> same response.
4. Overflow with start=0xFFF0, step=0x20, points=2, shots=1, settle=0:
   - After point 0 completes, err=1, del_out=0xFFFF, done=1.
   - Only 1 del_update.
5. Abort:
   - Assert abort during ACQ of point 1 of 3 -> busy=0 next cycle, acq_en=0, no done.
   - del_out holds step-1 value; new cfg accepted afterwards with err cleared.
6. Boundary strobes:
   - period_end coincident with a STEP cycle -> not counted; point still receives exactly shots strobes with acq_en=1.
   - cfg_valid while busy -> ignored (cfg_ready=0).
